// File: rtl/clock_gen_multi.sv
// clock_gen_multi
//   Generates NUM_CH independent divided clocks from the master clock. Each
//   channel has a runtime-programmable half-period and an output inversion.
//   New settings are held pending and only take effect at the end of a full
//   output period (or on the next cycle for a stopped channel), so no runt
//   pulses are produced. sync_start restarts every channel in phase.
//
// Ports
//   clock        in   master clock, all flops on the rising edge
//   reset        in   asynchronous, active-high reset
//   cfg_wr       in   one-cycle configuration write strobe
//   cfg_ch       in   channel addressed by cfg_wr (>= NUM_CH ignored)
//   cfg_half     in   new half-period in master cycles, 0 stops the channel
//   cfg_inv      in   new output inversion
//   sync_start   in   phase-align all channels, applying pending settings
//   clk_out      out  divided clocks, one flop per channel
//   tick         out  one-cycle pulse on each rising edge of clk_out[i]
//   cfg_pending  out  channel i holds a configuration awaiting its boundary
module clock_gen_multi #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 8,
  parameter int CH_W         = 2,
  parameter int DEFAULT_HALF = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cfg_wr,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_half,
  input  logic              cfg_inv,
  input  logic              sync_start,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] cfg_pending
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, half_d;
    logic [CNT_W-1:0] pend_half_q, pend_half_d;
    logic             ph_q, ph_d;
    logic             inv_q, inv_d;
    logic             pend_q, pend_d;
    logic             pend_inv_q, pend_inv_d;
    logic             clk_q, clk_d;
    logic             tick_q, tick_d;
    logic             wr_hit;
    logic             apply;

    // Only addresses below NUM_CH match a channel, so out-of-range writes
    // fall through without touching any state.
    assign wr_hit = cfg_wr && (cfg_ch == CH_W'(i));

    always_comb begin
      cnt_d       = cnt_q;
      ph_d        = ph_q;
      half_d      = half_q;
      inv_d       = inv_q;
      pend_d      = pend_q;
      pend_half_d = pend_half_q;
      pend_inv_d  = pend_inv_q;
      apply       = 1'b0;

      if (sync_start) begin
        cnt_d = '0;
        ph_d  = 1'b0;
        apply = pend_q;
      end else if (half_q == '0) begin
        cnt_d = '0;
        ph_d  = 1'b0;
        apply = pend_q;
      end else if (cnt_q == half_q - CNT_W'(1)) begin
        cnt_d = '0;
        ph_d  = ~ph_q;
        // ph falling 1->0 closes a full period: the only safe switch point.
        apply = pend_q & ph_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      if (apply) begin
        half_d = pend_half_q;
        inv_d  = pend_inv_q;
        pend_d = 1'b0;
        cnt_d  = '0;
        ph_d   = 1'b0;
      end

      // A write in the same cycle as an apply is kept for the next boundary.
      if (wr_hit) begin
        pend_half_d = cfg_half;
        pend_inv_d  = cfg_inv;
        pend_d      = 1'b1;
      end

      // ph is held at 0 while stopped, so this also yields inv for that case.
      clk_d  = ph_d ^ inv_d;
      tick_d = clk_d & ~clk_q & (half_d != '0) & ~sync_start;
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        cnt_q       <= '0;
        ph_q        <= 1'b0;
        half_q      <= CNT_W'(DEFAULT_HALF);
        inv_q       <= 1'b0;
        pend_q      <= 1'b0;
        pend_half_q <= '0;
        pend_inv_q  <= 1'b0;
        clk_q       <= 1'b0;
        tick_q      <= 1'b0;
      end else begin
        cnt_q       <= cnt_d;
        ph_q        <= ph_d;
        half_q      <= half_d;
        inv_q       <= inv_d;
        pend_q      <= pend_d;
        pend_half_q <= pend_half_d;
        pend_inv_q  <= pend_inv_d;
        clk_q       <= clk_d;
        tick_q      <= tick_d;
      end
    end

    assign clk_out[i]     = clk_q;
    assign tick[i]        = tick_q;
    assign cfg_pending[i] = pend_q;
  end

endmodule

// File: tb/tb_clock_gen_multi.sv
module tb_clock_gen_multi;
  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;
  localparam int CH_W   = 3;
  localparam int DEF    = 4;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              cfg_wr = 1'b0;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_half = '0;
  logic              cfg_inv = 1'b0;
  logic              sync_start = 1'b0;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] cfg_pending;

  clock_gen_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .CH_W(CH_W), .DEFAULT_HALF(DEF)
  ) dut (
    .clock(clock), .reset(reset), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_half(cfg_half), .cfg_inv(cfg_inv), .sync_start(sync_start),
    .clk_out(clk_out), .tick(tick), .cfg_pending(cfg_pending)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NUM_CH-1:0] clk;
    logic [NUM_CH-1:0] tk;
    logic [NUM_CH-1:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: each channel is described by its position within the
  // output period (0 .. 2*half-1); the output is high in the second half.
  int                m_pos   [NUM_CH];
  int                m_half  [NUM_CH];
  bit                m_inv   [NUM_CH];
  bit                m_pend  [NUM_CH];
  int                m_phalf [NUM_CH];
  bit                m_pinv  [NUM_CH];
  logic [NUM_CH-1:0] m_clk;
  logic [NUM_CH-1:0] m_tick;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_pos[i] = 0; m_half[i] = DEF; m_inv[i] = 0;
      m_pend[i] = 0; m_phalf[i] = 0; m_pinv[i] = 0;
    end
    m_clk = '0;
    m_tick = '0;
  endtask

  task automatic model_step(input bit wr, input int ch, input int half,
                            input bit inv, input bit sync);
    exp_t e;
    if (reset) begin
      model_reset();
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        bit apply = 0;
        bit nclk;
        if (sync || m_half[i] == 0) begin
          m_pos[i] = 0;
          apply = m_pend[i];
        end else if (m_pos[i] == 2 * m_half[i] - 1) begin
          m_pos[i] = 0;
          apply = m_pend[i];
        end else begin
          m_pos[i]++;
        end
        if (apply) begin
          m_half[i] = m_phalf[i];
          m_inv[i]  = m_pinv[i];
          m_pend[i] = 0;
          m_pos[i]  = 0;
        end
        if (wr && ch == i) begin
          m_phalf[i] = half;
          m_pinv[i]  = inv;
          m_pend[i]  = 1;
        end
        nclk = (m_half[i] == 0) ? m_inv[i] : ((m_pos[i] >= m_half[i]) ^ m_inv[i]);
        m_tick[i] = nclk && !m_clk[i] && (m_half[i] != 0) && !sync;
        m_clk[i]  = nclk;
      end
    end
    for (int i = 0; i < NUM_CH; i++) e.pend[i] = m_pend[i];
    e.clk = m_clk;
    e.tk  = m_tick;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus, record the expected post-edge outputs and
  // advance to just after the following falling edge.
  task automatic step(input bit wr, input int ch, input int half,
                      input bit inv, input bit sync);
    cfg_wr     = wr;
    cfg_ch     = CH_W'(ch);
    cfg_half   = CNT_W'(half);
    cfg_inv    = inv;
    sync_start = sync;
    model_step(wr, ch, half, inv, sync);
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
  endtask

  // Assert reset between edges and confirm the outputs clear without a clock.
  task automatic reset_mid();
    reset = 1'b1;
    #1;
    checks++;
    if (clk_out !== '0 || tick !== '0 || cfg_pending !== '0) begin
      errors++;
      $display("FAIL async_reset t=%0t got clk=%b tick=%b pend=%b want all 0",
               $time, clk_out, tick, cfg_pending);
    end
    step(0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  // Monitor: every falling edge follows exactly one rising edge, so one
  // queued expectation is consumed per cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      if (clk_out !== e.clk) begin
        errors++;
        $display("FAIL clk_out t=%0t got %b want %b", $time, clk_out, e.clk);
      end
      checks++;
      if (tick !== e.tk) begin
        errors++;
        $display("FAIL tick t=%0t got %b want %b", $time, tick, e.tk);
      end
      checks++;
      if (cfg_pending !== e.pend) begin
        errors++;
        $display("FAIL cfg_pending t=%0t got %b want %b", $time, cfg_pending, e.pend);
      end
    end
  end

  initial begin
    model_reset();
    // Reset state, then defaults running for 32 cycles.
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    idle(32);

    // Channel 1 reprogrammed mid-period.
    idle(5);
    step(1, 1, 2, 0, 0);
    idle(12);

    // Overwrite before the boundary: only the second write lands.
    step(1, 2, 3, 0, 0);
    idle(1);
    step(1, 2, 1, 0, 0);
    idle(16);

    // Stop channel 0 with inversion, then restart it from the stopped state.
    step(1, 0, 0, 1, 0);
    idle(12);
    step(1, 0, 5, 0, 0);
    idle(24);

    // Out-of-phase channels, an out-of-range write, then sync_start.
    step(1, 0, 3, 0, 0);
    step(1, 3, 6, 0, 0);
    idle(17);
    step(1, 7, 9, 1, 0);
    idle(1);
    step(0, 0, 0, 0, 1);
    idle(20);
    step(1, 1, 2, 1, 0);
    step(1, 1, 3, 0, 1);
    idle(12);

    // Reset while a write is pending.
    step(1, 1, 7, 0, 0);
    idle(3);
    reset_mid();
    idle(20);

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      bit wr   = ($urandom % 4) == 0;
      int ch   = int'($urandom % 8);
      int half = (($urandom % 8) == 0) ? int'($urandom % 256) : int'($urandom % 6);
      bit inv  = $urandom % 2;
      bit sync = ($urandom % 40) == 0;
      if (($urandom % 700) == 0) reset_mid();
      step(wr, ch, half, inv, sync);
    end
    idle(4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d queued want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t got no finish want finish", $time);
    $fatal(1, "timeout");
  end

endmodule
